// File: rtl/xmit_pkg.sv
// Shared types and constants for the transmit priority scheduler:
// FSM state encoding, control-word length field position and default
// parameter values.
package xmit_pkg;

    localparam int CTRL_W  = 24;
    localparam int LEN_MSB = 11;
    localparam int LEN_LSB = 0;
    localparam int LEN_W   = LEN_MSB - LEN_LSB + 1;

    localparam int DEF_IFG_CYCLES   = 12;
    localparam int DEF_MAX_LEN      = 1518;
    localparam int DEF_HI_BURST_MAX = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DROP = 2'd2,
        ST_IFG  = 2'd3
    } xmit_state_e;

    typedef logic [LEN_W-1:0] len_t;

endpackage

// File: rtl/xmit_priority_sched_if.sv
// Control-FIFO, data-FIFO and serializer handshake bundle of the
// transmit priority scheduler. The slave modport is the scheduler side.
interface xmit_priority_sched_if;
    import xmit_pkg::*;

    logic              hi_ctrl_valid;
    logic [CTRL_W-1:0] hi_ctrl_in;
    logic              lo_ctrl_valid;
    logic [CTRL_W-1:0] lo_ctrl_in;
    logic              tx_byte_ready;
    logic              hi_ctrl_pop;
    logic              lo_ctrl_pop;
    logic              hi_data_rd;
    logic              lo_data_rd;
    logic              tx_sel;
    logic              tx_start;
    logic              tx_last;
    logic              tx_busy;
    logic              m_discard_en;

    modport master (
        output hi_ctrl_valid, hi_ctrl_in, lo_ctrl_valid, lo_ctrl_in, tx_byte_ready,
        input  hi_ctrl_pop, lo_ctrl_pop, hi_data_rd, lo_data_rd,
               tx_sel, tx_start, tx_last, tx_busy, m_discard_en
    );

    modport slave (
        input  hi_ctrl_valid, hi_ctrl_in, lo_ctrl_valid, lo_ctrl_in, tx_byte_ready,
        output hi_ctrl_pop, lo_ctrl_pop, hi_data_rd, lo_data_rd,
               tx_sel, tx_start, tx_last, tx_busy, m_discard_en
    );

endinterface

// File: rtl/xmit_ifg_timer.sv
// Inter-frame gap timer. 'load' arms it with CYCLES; while 'count' is
// high it counts down, and 'done' flags the final gap cycle.
module xmit_ifg_timer
    import xmit_pkg::*;
#(
    parameter int CYCLES = DEF_IFG_CYCLES
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic load,
    input  logic count,
    output logic done
);

    localparam int W = (CYCLES < 2) ? 1 : $clog2(CYCLES + 1);

    logic [W-1:0] remain_q;

    // Remaining gap cycles: reload on entry, count down while in the gap.
    always_ff @(posedge clk_sys) begin
        // NOTE: sequential state is only ever written with <= so every
        // register samples pre-edge values regardless of block ordering.
        if (reset) begin
            remain_q <= '0;
        end else if (load) begin
            remain_q <= W'(CYCLES);
        end else if (count && remain_q != '0) begin
            remain_q <= remain_q - W'(1);
        end
    end

    assign done = count && (remain_q == W'(1));

endmodule

// File: rtl/xmit_priority_sched.sv
// Two-queue transmit scheduler: grants the hi or lo control FIFO, then
// streams (SEND), discards (DROP) or skips the frame, followed by a
// fixed inter-frame gap.
// Build option: define XMIT_ANTI_STARVE_EN to cap consecutive hi grants
// at HI_BURST_MAX while a lo frame waits; otherwise strict hi priority.
module xmit_priority_sched
    import xmit_pkg::*;
#(
    parameter int IFG_CYCLES   = DEF_IFG_CYCLES,
    parameter int MAX_LEN      = DEF_MAX_LEN,
    parameter int HI_BURST_MAX = DEF_HI_BURST_MAX
) (
    input logic                  clk_sys,
    input logic                  reset,
    xmit_priority_sched_if.slave bus
);

    localparam len_t MAX_LEN_L = LEN_W'(MAX_LEN);

    xmit_state_e state_q, state_d;
    len_t        cnt_q, cnt_d;
    logic        sel_q, sel_d;
    logic        first_q, first_d;

    logic        hi_win;
    logic        grant_hi, grant_lo;
    len_t        hi_len, lo_len, grant_len;
    logic        rd, last, discard;
    logic        timer_load, timer_count, timer_done;
    logic        unused_ctrl;

    assign hi_len      = bus.hi_ctrl_in[LEN_MSB:LEN_LSB];
    assign lo_len      = bus.lo_ctrl_in[LEN_MSB:LEN_LSB];
    assign unused_ctrl = ^{bus.hi_ctrl_in[CTRL_W-1:LEN_MSB+1], bus.lo_ctrl_in[CTRL_W-1:LEN_MSB+1]};

`ifdef XMIT_ANTI_STARVE_EN
    localparam int BW = $clog2(HI_BURST_MAX + 1);

    logic [BW-1:0] burst_cnt_q;

    assign hi_win = bus.hi_ctrl_valid &&
                    ((burst_cnt_q < BW'(HI_BURST_MAX)) || !bus.lo_ctrl_valid);

    // Consecutive hi grants: saturating count, cleared by any lo grant.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            burst_cnt_q <= '0;
        end else if (grant_lo) begin
            burst_cnt_q <= '0;
        end else if (grant_hi && burst_cnt_q != BW'(HI_BURST_MAX)) begin
            burst_cnt_q <= burst_cnt_q + BW'(1);
        end
    end
`else
    logic unused_cfg;

    assign hi_win     = bus.hi_ctrl_valid;
    assign unused_cfg = (HI_BURST_MAX != 0);
`endif

    assign grant_len = grant_hi ? hi_len : lo_len;

    // Next-state, grant and datapath strobes for the scheduler FSM.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves one unassigned and a latch cannot be inferred.
        state_d     = state_q;
        cnt_d       = cnt_q;
        sel_d       = sel_q;
        first_d     = 1'b0;
        grant_hi    = 1'b0;
        grant_lo    = 1'b0;
        rd          = 1'b0;
        last        = 1'b0;
        discard     = 1'b0;
        timer_load  = 1'b0;
        timer_count = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (hi_win) begin
                    grant_hi = 1'b1;
                end else if (bus.lo_ctrl_valid) begin
                    grant_lo = 1'b1;
                end
                if (grant_hi || grant_lo) begin
                    sel_d = grant_hi;
                    cnt_d = grant_len;
                    if (grant_len == '0) begin
                        // Empty descriptor: flag the drop and stay idle.
                        discard = 1'b1;
                    end else if (grant_len > MAX_LEN_L) begin
                        state_d = ST_DROP;
                    end else begin
                        state_d = ST_SEND;
                        first_d = 1'b1;
                    end
                end
            end

            ST_SEND: begin
                rd = bus.tx_byte_ready;
                if (bus.tx_byte_ready) begin
                    cnt_d = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        last = 1'b1;
                        if (IFG_CYCLES == 0) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d    = ST_IFG;
                            timer_load = 1'b1;
                        end
                    end
                end
            end

            ST_DROP: begin
                rd      = 1'b1;
                discard = 1'b1;
                cnt_d   = cnt_q - LEN_W'(1);
                if (cnt_q == LEN_W'(1)) begin
                    if (IFG_CYCLES == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d    = ST_IFG;
                        timer_load = 1'b1;
                    end
                end
            end

            ST_IFG: begin
                timer_count = 1'b1;
                if (timer_done) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state, byte counter, granted-queue select and start flag.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sel_q   <= 1'b0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            first_q <= first_d;
        end
    end

    xmit_ifg_timer #(
        .CYCLES (IFG_CYCLES)
    ) u_ifg_timer (
        .clk_sys (clk_sys),
        .reset   (reset),
        .load    (timer_load),
        .count   (timer_count),
        .done    (timer_done)
    );

    // Strobes are masked during reset so no FIFO is popped or read then.
    assign bus.hi_ctrl_pop  = grant_hi & ~reset;
    assign bus.lo_ctrl_pop  = grant_lo & ~reset;
    assign bus.hi_data_rd   = rd &  sel_q & ~reset;
    assign bus.lo_data_rd   = rd & ~sel_q & ~reset;
    assign bus.tx_sel       = sel_q;
    assign bus.tx_start     = first_q & ~reset;
    assign bus.tx_last      = last & ~reset;
    assign bus.tx_busy      = (state_q != ST_IDLE);
    assign bus.m_discard_en = discard & ~reset;

endmodule

// File: tb/tb_xmit_priority_sched.sv
// Directed testbench for xmit_priority_sched with a small FIFO-occupancy
// model on the control side and per-cycle event counters on the outputs.
module tb_xmit_priority_sched;

    logic clk_sys;
    logic reset;

    xmit_priority_sched_if bus ();

    xmit_priority_sched dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (bus)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    int total = 0;
    int bad   = 0;

    // Stimulus state
    logic        rst_drv;
    int          hi_left, lo_left;
    logic [23:0] hi_word, lo_word;
    int          ready_mode;

    // Monitor state
    int          cyc;
    logic [8:0]  obs;
    logic        last_busy, last_popped;
    int          n_hi_pop, n_lo_pop, n_hi_rd, n_lo_rd;
    int          n_start, n_last, n_disc, n_busy;
    int          frame_rd, last_at, since_rd;
    int          first_rd_cyc, last_rd_cyc, min_gap;
    int          viol;
    string       order;

    task automatic clear_stats();
        n_hi_pop = 0; n_lo_pop = 0; n_hi_rd = 0; n_lo_rd = 0;
        n_start = 0; n_last = 0; n_disc = 0; n_busy = 0;
        frame_rd = 0; last_at = -1; since_rd = 0;
        first_rd_cyc = -1; last_rd_cyc = -1; min_gap = 1000000;
        order = "";
    endtask

    // One clock: drive inputs after the falling edge, sample 1 ns later.
    task automatic cycle();
        logic rd_any;
        @(negedge clk_sys);
        reset             = rst_drv;
        bus.hi_ctrl_valid = (hi_left > 0);
        bus.hi_ctrl_in    = hi_word;
        bus.lo_ctrl_valid = (lo_left > 0);
        bus.lo_ctrl_in    = lo_word;
        bus.tx_byte_ready = (ready_mode == 0) ? 1'b1 : ((cyc % 4) == 0);
        #1;
        obs = {bus.hi_ctrl_pop, bus.lo_ctrl_pop, bus.hi_data_rd, bus.lo_data_rd,
               bus.tx_sel, bus.tx_start, bus.tx_last, bus.tx_busy, bus.m_discard_en};
        if (bus.hi_ctrl_pop && bus.lo_ctrl_pop) viol++;
        if (bus.hi_data_rd && bus.lo_data_rd) viol++;
        if (bus.hi_data_rd && !bus.tx_sel) viol++;
        if (bus.lo_data_rd && bus.tx_sel) viol++;
        last_popped = bus.hi_ctrl_pop || bus.lo_ctrl_pop;
        last_busy   = bus.tx_busy;
        if (last_popped) begin
            if (last_rd_cyc >= 0 && (cyc - last_rd_cyc) < min_gap) min_gap = cyc - last_rd_cyc;
            frame_rd = 0;
            if (bus.hi_ctrl_pop) begin
                n_hi_pop++; hi_left--; order = {order, "H"};
            end else begin
                n_lo_pop++; lo_left--; order = {order, "L"};
            end
        end
        rd_any = bus.hi_data_rd || bus.lo_data_rd;
        if (bus.hi_data_rd) n_hi_rd++;
        if (bus.lo_data_rd) n_lo_rd++;
        if (rd_any) begin
            frame_rd++;
            if (first_rd_cyc < 0) first_rd_cyc = cyc;
            last_rd_cyc = cyc;
            since_rd = 0;
        end else if (bus.tx_busy) begin
            since_rd++;
        end
        if (bus.tx_last) begin
            n_last++;
            last_at = frame_rd;
        end
        if (bus.tx_start) n_start++;
        if (bus.m_discard_en) n_disc++;
        if (bus.tx_busy) n_busy++;
        cyc++;
    endtask

    // Run until both queues are drained and the scheduler is back in IDLE.
    task automatic run_frames(input int budget, input string name);
        int n = 0;
        do begin
            cycle();
            n++;
        end while (!(hi_left == 0 && lo_left == 0 && !last_busy && !last_popped) && n < budget);
        total++;
        if (n >= budget) begin
            bad++;
            $display("FAIL %s_timeout: ran %0d cycles, required completion within %0d", name, n, budget);
        end
    endtask

    task automatic test_reset();
        hi_word = 24'h000004; hi_left = 1;
        rst_drv = 1'b1;
        cycle();
        cycle();
        total++;
        if (obs[8:5] !== 4'b0000) begin
            bad++; $display("FAIL reset_no_pop: pop/rd=%b required 0000", obs[8:5]);
        end
        rst_drv = 1'b0;
        clear_stats();
        cycle();
        total++;
        if (obs !== 9'b1_0000_0000) begin
            bad++; $display("FAIL reset_first_cycle: outputs=%b required 100000000", obs);
        end
        run_frames(100, "reset_drain");
        total++;
        if (n_hi_rd !== 4 || n_last !== 1 || last_at !== 4) begin
            bad++; $display("FAIL reset_drain: rd=%0d last=%0d at=%0d required 4 1 4", n_hi_rd, n_last, last_at);
        end
    endtask

    task automatic test_single_lo();
        clear_stats();
        lo_word = 24'h200200; lo_left = 1;
        run_frames(2000, "single_lo");
        total++;
        if (n_lo_pop !== 1 || n_hi_pop !== 0) begin
            bad++; $display("FAIL single_pops: lo=%0d hi=%0d required 1 0", n_lo_pop, n_hi_pop);
        end
        total++;
        if (n_lo_rd !== 512 || n_hi_rd !== 0) begin
            bad++; $display("FAIL single_reads: lo=%0d hi=%0d required 512 0", n_lo_rd, n_hi_rd);
        end
        total++;
        if (n_last !== 1 || last_at !== 512) begin
            bad++; $display("FAIL single_last: count=%0d at=%0d required 1 512", n_last, last_at);
        end
        total++;
        if (n_start !== 1) begin
            bad++; $display("FAIL single_start: count=%0d required 1", n_start);
        end
        total++;
        if (since_rd !== 12) begin
            bad++; $display("FAIL single_ifg: gap=%0d required 12", since_rd);
        end
        total++;
        if (n_busy !== 512 + 12) begin
            bad++; $display("FAIL single_busy: cycles=%0d required 524", n_busy);
        end
    endtask

    task automatic test_sparse_ready();
        clear_stats();
        ready_mode = 1;
        hi_word = 24'h000008; hi_left = 1;
        run_frames(200, "sparse");
        ready_mode = 0;
        total++;
        if (n_hi_rd !== 8) begin
            bad++; $display("FAIL sparse_reads: got=%0d required 8", n_hi_rd);
        end
        total++;
        if ((last_rd_cyc - first_rd_cyc + 1) !== 29) begin
            bad++; $display("FAIL sparse_span: got=%0d required 29", last_rd_cyc - first_rd_cyc + 1);
        end
        total++;
        if (n_last !== 1 || last_at !== 8) begin
            bad++; $display("FAIL sparse_last: count=%0d at=%0d required 1 8", n_last, last_at);
        end
    endtask

    task automatic test_drop();
        clear_stats();
        hi_word = 24'h0007D0; hi_left = 1;
        run_frames(2200, "drop");
        total++;
        if (n_disc !== 2000) begin
            bad++; $display("FAIL drop_discard: cycles=%0d required 2000", n_disc);
        end
        total++;
        if (n_hi_rd !== 2000 || n_lo_rd !== 0) begin
            bad++; $display("FAIL drop_reads: hi=%0d lo=%0d required 2000 0", n_hi_rd, n_lo_rd);
        end
        total++;
        if (n_start !== 0 || n_last !== 0) begin
            bad++; $display("FAIL drop_start_last: start=%0d last=%0d required 0 0", n_start, n_last);
        end
        total++;
        if (since_rd !== 12) begin
            bad++; $display("FAIL drop_ifg: gap=%0d required 12", since_rd);
        end
    endtask

    task automatic test_zero_len();
        clear_stats();
        lo_word = 24'hFFF000; lo_left = 1;
        run_frames(50, "zero");
        total++;
        if (n_disc !== 1) begin
            bad++; $display("FAIL zero_discard: cycles=%0d required 1", n_disc);
        end
        total++;
        if (n_lo_rd !== 0 || n_hi_rd !== 0) begin
            bad++; $display("FAIL zero_reads: lo=%0d hi=%0d required 0 0", n_lo_rd, n_hi_rd);
        end
        total++;
        if (n_lo_pop !== 1 || n_busy !== 0) begin
            bad++; $display("FAIL zero_pop_busy: pop=%0d busy=%0d required 1 0", n_lo_pop, n_busy);
        end
    endtask

    task automatic test_priority();
        string exp_order;
`ifdef XMIT_ANTI_STARVE_EN
        exp_order = "HHHHLHHLLLLL";
`else
        exp_order = "HHHHHHLLLLLL";
`endif
        rst_drv = 1'b1;
        cycle();
        rst_drv = 1'b0;
        clear_stats();
        hi_word = 24'h000010; lo_word = 24'h000010;
        hi_left = 6; lo_left = 6;
        run_frames(1000, "priority");
        total++;
        if (order != exp_order) begin
            bad++; $display("FAIL prio_order: got=%s required %s", order, exp_order);
        end
        total++;
        if (n_hi_rd !== 96 || n_lo_rd !== 96) begin
            bad++; $display("FAIL prio_reads: hi=%0d lo=%0d required 96 96", n_hi_rd, n_lo_rd);
        end
        total++;
        if (min_gap !== 13) begin
            bad++; $display("FAIL prio_spacing: min=%0d required 13", min_gap);
        end
        total++;
        if (viol !== 0) begin
            bad++; $display("FAIL prio_exclusive: violations=%0d required 0", viol);
        end
    endtask

    task automatic test_reset_mid_frame();
        int n = 0;
        clear_stats();
        hi_word = 24'h000200; hi_left = 1;
        do begin
            cycle();
            n++;
        end while (frame_rd != 100 && n < 400);
        total++;
        if (frame_rd !== 100) begin
            bad++; $display("FAIL midrst_reach: reads=%0d required 100", frame_rd);
        end
        rst_drv = 1'b1;
        cycle();
        total++;
        if (obs[8:5] !== 4'b0000) begin
            bad++; $display("FAIL midrst_no_read: pop/rd=%b required 0000", obs[8:5]);
        end
        rst_drv = 1'b0;
        cycle();
        total++;
        if (obs !== 9'b0) begin
            bad++; $display("FAIL midrst_outputs: outputs=%b required 000000000", obs);
        end
        clear_stats();
        hi_word = 24'h000004; hi_left = 1;
        run_frames(100, "midrst_fresh");
        total++;
        if (n_hi_rd !== 4 || last_at !== 4 || n_start !== 1) begin
            bad++; $display("FAIL midrst_fresh: rd=%0d at=%0d start=%0d required 4 4 1", n_hi_rd, last_at, n_start);
        end
        total++;
        if (viol !== 0) begin
            bad++; $display("FAIL exclusive_total: violations=%0d required 0", viol);
        end
    endtask

    initial begin
        rst_drv = 1'b1; reset = 1'b1;
        hi_left = 0; lo_left = 0; hi_word = '0; lo_word = '0;
        ready_mode = 0; cyc = 0; viol = 0;
        last_busy = 1'b0; last_popped = 1'b0; obs = '0;
        bus.hi_ctrl_valid = 1'b0; bus.hi_ctrl_in = '0;
        bus.lo_ctrl_valid = 1'b0; bus.lo_ctrl_in = '0;
        bus.tx_byte_ready = 1'b0;
        clear_stats();

        test_reset();
        test_single_lo();
        test_sparse_ready();
        test_drop();
        test_zero_len();
        test_priority();
        test_reset_mid_frame();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
